// File: rtl/ok_ep_pkg.sv
// Shared constants for the host-interface endpoint slice.
// Address windows, default data width and the synchronizer depth floor.
package ok_ep_pkg;

   localparam logic [7:0] TRIG_OUT_ADDR_MIN = 8'h60;
   localparam logic [7:0] TRIG_OUT_ADDR_MAX = 8'h7F;
   localparam int         OK_EP_WIDTH       = 32;
   localparam int         OK_SYNC_MIN       = 2;

   // A misconfigured endpoint must never alias onto another endpoint class.
   function automatic logic trig_out_addr_ok(input logic [7:0] a);
      return (a >= TRIG_OUT_ADDR_MIN) && (a <= TRIG_OUT_ADDR_MAX);
   endfunction

endpackage

// File: rtl/ok_toggle_sync.sv
// Toggle synchronizer: SYNC_STAGES flops into the destination domain plus an
// edge-detect flop, giving one destination-clock pulse per source toggle.
module ok_toggle_sync
   import ok_ep_pkg::*;
#(
   parameter int SYNC_STAGES = 2
)(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_tgl,
   output logic o_pulse
);

   localparam int STAGES = (SYNC_STAGES < OK_SYNC_MIN) ? OK_SYNC_MIN : SYNC_STAGES;

   logic [STAGES-1:0] r_sync;
   logic              r_last;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '0;
         r_last <= 1'b0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_tgl};
         r_last <= r_sync[STAGES-1];
      end
   end

   assign o_pulse = r_sync[STAGES-1] ^ r_last;

endmodule

// File: rtl/ok_trigger_out.sv
// Trigger-out endpoint: sticky event accumulator in ep_clk, snapshotted on a
// host update and handed to ti_clk via a toggle req/ack handshake.
module ok_trigger_out
   import ok_ep_pkg::*;
#(
   parameter int WIDTH       = OK_EP_WIDTH,
   parameter int SYNC_STAGES = 2
)(
   input  logic             ti_reset,
   input  logic             ep_clk,
   input  logic             ti_clk,
   input  logic [7:0]       ep_addr,
   input  logic [WIDTH-1:0] ep_trigger,
   input  logic             ti_update,
   input  logic             ti_read,
   input  logic [7:0]       ti_addr,
   output logic [WIDTH-1:0] ti_dataout,
   output logic             ti_busy
);

   // ep_clk domain
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_snap;
   logic             r_ack_t;
   logic             w_cap;

   // ti_clk domain
   logic [WIDTH-1:0] r_hold;
   logic             r_req_t;
   logic             r_busy;
   logic             w_ack_edge;
   logic             w_accept;
   logic             w_sel;

   ok_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
      .i_clk   (ep_clk),
      .i_rst   (ti_reset),
      .i_tgl   (r_req_t),
      .o_pulse (w_cap)
   );

   ok_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
      .i_clk   (ti_clk),
      .i_rst   (ti_reset),
      .i_tgl   (r_ack_t),
      .o_pulse (w_ack_edge)
   );

   // A pulse in the capture cycle seeds the fresh accumulator, so it is
   // neither lost nor reported twice.
   always_ff @(posedge ep_clk or posedge ti_reset) begin
      if (ti_reset) begin
         r_acc   <= '0;
         r_snap  <= '0;
         r_ack_t <= 1'b0;
      end else if (w_cap) begin
         r_snap  <= r_acc;
         r_acc   <= ep_trigger;
         r_ack_t <= ~r_ack_t;
      end else begin
         r_acc   <= r_acc | ep_trigger;
      end
   end

   assign w_accept = ti_update & ~r_busy;

   // r_snap is frozen from capture until the next request, so sampling it
   // whole on the ack edge is safe without per-bit synchronizers.
   always_ff @(posedge ti_clk or posedge ti_reset) begin
      if (ti_reset) begin
         r_req_t <= 1'b0;
         r_busy  <= 1'b0;
         r_hold  <= '0;
      end else begin
         if (w_accept) begin
            r_req_t <= ~r_req_t;
            r_busy  <= 1'b1;
         end
         if (w_ack_edge) begin
            r_hold  <= r_snap;
            r_busy  <= 1'b0;
         end
      end
   end

   assign w_sel      = ti_read && (ti_addr == ep_addr) && trig_out_addr_ok(ep_addr);
   assign ti_dataout = w_sel ? r_hold : '0;
   assign ti_busy    = r_busy;

endmodule

// File: tb/tb_ok_trigger_out.sv
// Bench for ok_trigger_out: directed vectors against a timing-window model,
// then an async-clock event-conservation run.
`timescale 1ns/1ps
module tb_ok_trigger_out;

   logic        ti_reset = 1'b1;
   logic        ep_clk   = 1'b0;
   logic        ti_clk   = 1'b0;
   logic [7:0]  ep_addr  = 8'h60;
   logic [31:0] ep_trigger = '0;
   logic        ti_update = 1'b0;
   logic        ti_read   = 1'b1;
   logic [7:0]  ti_addr   = 8'h60;
   logic [31:0] ti_dataout;
   logic        ti_busy;

   real ep_half = 5.0;
   always #(ep_half) ep_clk = ~ep_clk;
   always #5 ti_clk = ~ti_clk;

   ok_trigger_out #(.WIDTH(32), .SYNC_STAGES(2)) dut (
      .ti_reset   (ti_reset),
      .ep_clk     (ep_clk),
      .ti_clk     (ti_clk),
      .ep_addr    (ep_addr),
      .ep_trigger (ep_trigger),
      .ti_update  (ti_update),
      .ti_read    (ti_read),
      .ti_addr    (ti_addr),
      .ti_dataout (ti_dataout),
      .ti_busy    (ti_busy)
   );

   int n_vec = 0;
   int n_err = 0;
   int tcyc  = 0;
   always @(posedge ti_clk) tcyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model (equal in-phase clocks, so one edge count serves both domains):
   // an update sampled at edge e is taken iff e is after the previous done
   // edge; capture is edge e+3, hold/busy settle at edge e+6; a snapshot is
   // the OR of every trigger sampled in [previous capture, capture-1].
   logic [31:0] trig_log [int];
   bit          chk_on = 0;
   int          m_start = -100, m_done = -100, m_cap = 0, m_cp = 0;
   bit          m_pend = 0;
   logic [31:0] m_hold = '0;

   task automatic model_req(input int e);
      if (e > m_done) begin
         m_start = e;
         m_done  = e + 6;
         m_cap   = e + 3;
         m_pend  = 1;
      end
   endtask

   task automatic model_reset();
      m_start = -100; m_done = -100; m_pend = 0; m_hold = '0; m_cp = tcyc + 1;
   endtask

   always begin
      @(negedge ti_clk); #1;
      if (chk_on && !ti_reset) begin
         if (m_pend && tcyc >= m_done) begin
            logic [31:0] s;
            s = '0;
            for (int k = m_cp; k < m_cap; k++)
               if (trig_log.exists(k)) s |= trig_log[k];
            m_cp = m_cap; m_hold = s; m_pend = 0;
         end
         chk("busy_cycle", {31'd0, ti_busy}, {31'd0, (tcyc >= m_start && tcyc < m_done)});
         chk("dout_cycle", ti_dataout, (ti_read && ti_addr == ep_addr) ? m_hold : 32'd0);
      end
   end

   task automatic ti_cyc();
      @(negedge ti_clk);
   endtask

   task automatic pulse(input logic [31:0] v);
      @(negedge ti_clk); ep_trigger = v; trig_log[tcyc+1] = v;
      @(negedge ti_clk); ep_trigger = '0;
   endtask

   task automatic update();
      @(negedge ti_clk); ti_update = 1'b1;
      if (chk_on) model_req(tcyc + 1);
      @(negedge ti_clk); ti_update = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         @(negedge ti_clk); #1;
         if (!ti_busy) break;
      end
      chk("busy_timeout", {31'd0, ti_busy}, 32'd0);
   endtask

   task automatic check_read(input logic [7:0] a, input logic [31:0] exp, input string nm);
      @(negedge ti_clk); ti_addr = a; ti_read = 1'b1;
      #1 chk(nm, ti_dataout, exp);
      #1 ti_addr = ep_addr;
   endtask

   task automatic do_reset(input logic [7:0] new_addr);
      #2 ti_reset = 1'b1;
      #1 chk("rst_busy", {31'd0, ti_busy}, 32'd0);
      chk("rst_dout", ti_dataout, 32'd0);
      ep_addr = new_addr; ti_addr = new_addr;
      repeat (3) @(negedge ti_clk);
      ti_reset = 1'b0;
      model_reset();
   endtask

   int inj [32];
   int got [32];
   int npulse = 0;

   task automatic ep_drive(input logic [31:0] v);
      @(negedge ep_clk); ep_trigger = v;
      for (int i = 0; i < 32; i++) if (v[i]) begin inj[i]++; npulse++; end
   endtask

   task automatic collect();
      @(negedge ti_clk); #1;
      for (int i = 0; i < 32; i++) if (ti_dataout[i]) got[i]++;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int falls, rises;
      logic prev;
      logic [31:0] a, a_all, b, b_all, prev_b, v;
      for (int i = 0; i < 32; i++) begin inj[i] = 0; got[i] = 0; end

      repeat (3) @(negedge ti_clk);
      ti_reset = 1'b0;
      model_reset();
      chk_on = 1;

      // reset state
      check_read(8'h60, 32'h0, "reset_dout");
      chk("reset_busy", {31'd0, ti_busy}, 32'd0);

      // basic capture
      pulse(32'h0000_0001);
      repeat (2) ti_cyc();
      pulse(32'h8000_0000);
      update(); wait_idle();
      check_read(8'h60, 32'h8000_0001, "basic");
      check_read(8'h60, 32'h8000_0001, "reread");
      update(); wait_idle();
      check_read(8'h60, 32'h0, "empty");

      // pulse exactly in the capture cycle (update sampled at e, capture e+3)
      pulse(32'h0000_0100);
      update(); ti_cyc(); pulse(32'h0000_0010);
      wait_idle();
      check_read(8'h60, 32'h0000_0100, "bound_first");
      update(); wait_idle();
      check_read(8'h60, 32'h0000_0010, "bound_next");

      // second update while busy is ignored
      pulse(32'h0000_0003);
      update(); ti_cyc(); update();
      falls = 0; rises = 0; prev = 1'b1;
      repeat (20) begin
         @(negedge ti_clk); #1;
         if (prev && !ti_busy) falls++;
         if (!prev && ti_busy) rises++;
         prev = ti_busy;
      end
      chk("busy_falls", falls, 1);
      chk("busy_rerise", rises, 0);
      check_read(8'h60, 32'h0000_0003, "busy_snap");
      pulse(32'h0000_0004);
      update(); wait_idle();
      check_read(8'h60, 32'h0000_0004, "acc_once");

      // reset with hold=0xFF and a handshake in flight
      pulse(32'h0000_00FF);
      update(); wait_idle();
      check_read(8'h60, 32'h0000_00FF, "pre_reset");
      update();
      do_reset(8'h60);
      repeat (10) ti_cyc();
      check_read(8'h60, 32'h0, "post_reset");

      // address decode
      @(negedge ti_clk);
      do_reset(8'h61);
      pulse(32'hDEAD_BEEF);
      update(); wait_idle();
      check_read(8'h61, 32'hDEAD_BEEF, "addr_hit");
      check_read(8'h60, 32'h0, "addr_miss");
      check_read(8'h61, 32'hDEAD_BEEF, "addr_reread");

      // async clocks: each bit pulsed at most once per any snapshot window
      chk_on = 0;
      ep_half = 3.5;
      repeat (4) @(negedge ti_clk);
      prev_b = '0;
      for (int r = 0; r < 300 && npulse < 1000; r++) begin
         a = $urandom & ~prev_b; a_all = a;
         for (int c = 0; c < 4; c++) begin
            v = (c == 3) ? a : (a & $urandom); a &= ~v;
            ep_drive(v);
         end
         @(negedge ep_clk); ep_trigger = '0;
         repeat (2) @(negedge ep_clk);
         b = $urandom & $urandom & ~a_all & ~prev_b; b_all = b;
         fork
            begin
               @(negedge ti_clk); ti_update = 1'b1;
               @(negedge ti_clk); ti_update = 1'b0;
               wait_idle();
            end
            begin
               for (int c = 0; c < 3; c++) begin
                  v = (c == 2) ? b : (b & $urandom); b &= ~v;
                  ep_drive(v);
               end
               @(negedge ep_clk); ep_trigger = '0;
            end
         join
         collect();
         prev_b = b_all;
      end
      @(negedge ti_clk); ti_update = 1'b1;
      @(negedge ti_clk); ti_update = 1'b0;
      wait_idle();
      collect();
      for (int i = 0; i < 32; i++) chk($sformatf("bitcount[%0d]", i), got[i], inj[i]);
      chk("enough_pulses", {31'd0, npulse >= 1000}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
